fsm_stream_ctrl: RTL
====================

// Module: fsm_stream_ctrl
// PURPOSE
//   Sequencer for a 2-bit serial-input FSM (rstn/clk/x_in -> y_out).
//   Loads a WIDTH-bit word, clears the FSM, then drives the word into it MSB first, one bit per clock.
//   Captures the FSM's per-bit output into a result word and counts output hits.
//   Replaces hand-written bench stimulus with a repeatable start/done transaction.
// PARAMETERS
//   WIDTH  8  bits per transaction (>=2)
//   CNT_W  4  width of hit_count; saturates at 2**CNT_W-1
// PORTS
//   clk           in   1      system clock, rising-edge active
//   rstn          in   1      asynchronous reset, active low
//   start         in   1      request a transaction; sampled only in IDLE
//   data_in       in   WIDTH  word to stream; latched when start is accepted
//   y_in          in   1      FSM output (y_out) for the current x_out
//   x_out         out  1      serial bit to the FSM x_in
//   fsm_rstn_out  out  1      active-low reset to the FSM
//   busy          out  1      transaction in progress
//   done          out  1      one-cycle completion pulse
//   y_word        out  WIDTH  captured FSM outputs; first bit lands in the MSB
//   hit_count     out  CNT_W  number of y_in=1 samples, saturating
//   state         out  2      controller state, for debug
// BEHAVIOUR
//   Reset (rstn=0, async)
//     state=IDLE; x_out, busy, done = 0; y_word, hit_count, shift reg, bit index = 0.
//     fsm_rstn_out=0 while rstn=0.
//   States (encoding 2'b..)
//     IDLE=00: busy=0, x_out=0, fsm_rstn_out=1.
//       If start=1 at an edge: latch data_in, clear y_word/hit_count -> CLEAR.
//       Otherwise stay in IDLE.
//     CLEAR=01: busy=1, x_out=0, fsm_rstn_out=0 (combinational from state).
//       One cycle; index=0 -> SHIFT.
//     SHIFT=10: busy=1, fsm_rstn_out=1, x_out = shreg[WIDTH-1] (combinational).
//       At each edge:
//         y_word <= {y_word[WIDTH-2:0], y_in}
//         hit_count += y_in, holding at max
//         shreg <<= 1
//         index++
//       At the edge where index==WIDTH-1 -> DONE.
//     DONE=11: busy=1, done=1, x_out=0, fsm_rstn_out=1 -> IDLE next edge.
//   Timing
//     y_in is sampled on the same edge that advances x_out. The FSM is Mealy, so y_in is valid before that edge.
//     Latency: start accepted at edge E0 -> CLEAR after E0 -> SHIFT after E1.
//       WIDTH sample edges E2..E(WIDTH+1) -> done high from E(WIDTH+1) to E(WIDTH+2).
//     busy is high for WIDTH+2 cycles.
//     y_word and hit_count hold after DONE until the next accepted start.
//   Boundary cases
//     start while busy (CLEAR/SHIFT/DONE): ignored, no queueing.
//     start held high: the next transaction is accepted on the first edge in IDLE.
//       Back-to-back transactions therefore have exactly one IDLE cycle between them.
//     rstn low mid-SHIFT: immediate abort to reset values. No done pulse.
//       The partial y_word is discarded.
//     data_in changes after acceptance: no effect on the current transaction.
//     hit_count at 2**CNT_W-1 with y_in=1: stays at max.
// TESTING
//   1. y_in tied to x_out, data_in=8'hA5, start pulsed one cycle:
//      x_out sequence 1,0,1,0,0,1,0,1; y_word=8'hA5; hit_count=4.
//      done exactly 9 edges after the start edge; busy high for 10 cycles.
//   2. y_in=0, data_in=8'hFF: y_word=8'h00, hit_count=0.
//      fsm_rstn_out low for exactly 1 cycle, right after acceptance.
//   3. y_in=1, data_in=8'h00, CNT_W=2 build: y_word=8'hFF, hit_count=3 (saturated).
//   4. rstn low for 2 ns after the 3rd SHIFT edge:
//      all outputs 0 and fsm_rstn_out=0 during reset; no done pulse.
//      A new start with 8'h3C then completes with y_word=8'h3C (echo stub).
//   5. start pulsed again during SHIFT and again during DONE: both ignored.
//      Exactly one done pulse; y_word is unchanged by the extra starts.
//   6. start held high for 30 cycles, data 8'h81: done pulses every WIDTH+3=11 cycles.
//      An IDLE cycle precedes each CLEAR.

Source files
------------

// File: rtl/fsm_stream_ctrl.sv
// Transaction sequencer for a serial-input FSM: resets the FSM for one cycle, streams a
// latched word into it MSB first, and collects the per-bit outputs and a saturating hit count.
module fsm_stream_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             y_in,
    output logic             x_out,
    output logic             fsm_rstn_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y_word,
    output logic [CNT_W-1:0] hit_count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        SHIFT = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shreg;
    logic [IDX_W-1:0] idx;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = SHIFT;
            SHIFT:   if (idx == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg     <= '0;
            idx       <= '0;
            y_word    <= '0;
            hit_count <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg     <= data_in;
                        y_word    <= '0;
                        hit_count <= '0;
                    end
                end
                CLEAR: idx <= '0;
                SHIFT: begin
                    // y_in is the Mealy response to the bit currently on x_out.
                    y_word <= {y_word[WIDTH-2:0], y_in};
                    if (y_in && (hit_count != {CNT_W{1'b1}})) begin
                        hit_count <= hit_count + CNT_W'(1);
                    end
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                    idx   <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        x_out = 1'b0;
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
        if (state_q == SHIFT) x_out = shreg[WIDTH-1];
    end

    // The downstream FSM is held in reset whenever we are, not only during CLEAR.
    assign fsm_rstn_out = rstn && (state_q != CLEAR);
    assign state        = state_q;

endmodule
